// File: rtl/alu_pkg.sv
// Shared definitions for the streaming ALU: mode encodings, rounding constant
// and the accumulator-to-word narrowing helper.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_MAC = 3'd1,
    ALU_ADD = 3'd2,
    ALU_MAX = 3'd3,
    ALU_AVG = 3'd4
  } alu_mode_e;

  // Narrowing works on a 64-bit container so one function serves any word width.
  localparam int unsigned NarrowBits = 64;

  typedef struct packed {
    logic [NarrowBits-1:0] value;
    logic                  ovf;
  } narrow_t;

  // Unassigned codes fall back to NOP.
  function automatic alu_mode_e decode_mode(input logic [2:0] cfg);
    if (cfg > 3'd4) return ALU_NOP;
    return alu_mode_e'(cfg);
  endfunction

  // Half-LSB constant added before a right shift by frac bits (round-half-up).
  function automatic logic signed [63:0] round_shift(input int unsigned frac);
    if (frac == 0) return 64'sd0;
    return 64'sd1 <<< (frac - 1);
  endfunction

  function automatic narrow_t sat_narrow(input logic signed [63:0] v,
                                         input int unsigned        word_bits,
                                         input logic               sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] trunc;
    narrow_t            r;
    hi    = (64'sd1 <<< (word_bits - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (word_bits - 1));
    trunc = (v <<< (64 - word_bits)) >>> (64 - word_bits);
    r.ovf = (trunc != v);
    if (sat && (v > hi)) begin
      r.value = hi;
    end else if (sat && (v < lo)) begin
      r.value = lo;
    end else begin
      r.value = trunc;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_stream_if.sv
// Operand/result bundle between PE operand routing, the streaming ALU and the
// PE output register.
interface alu_stream_if #(
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned MAX_WIN   = 16
);
  localparam int unsigned WinBits = $clog2(MAX_WIN) + 1;

  logic                 En_in;
  logic [2:0]           CFG_in;
  logic                 ReLU_en_in;
  logic                 Sat_en_in;
  logic [WinBits-1:0]   Win_log2_in;
  logic                 S0_valid_in;
  logic [WORD_BITS-1:0] S0_in;
  logic                 S1_valid_in;
  logic [WORD_BITS-1:0] S1_in;
  logic                 Last_in;
  logic [WORD_BITS-1:0] Bias_in;
  logic [WORD_BITS-1:0] D0_out;
  logic                 Valid_out;
  logic                 Ovf_out;

  modport master (
    output En_in, CFG_in, ReLU_en_in, Sat_en_in, Win_log2_in, S0_valid_in, S0_in,
           S1_valid_in, S1_in, Last_in, Bias_in,
    input  D0_out, Valid_out, Ovf_out
  );

  modport slave (
    input  En_in, CFG_in, ReLU_en_in, Sat_en_in, Win_log2_in, S0_valid_in, S0_in,
           S1_valid_in, S1_in, Last_in, Bias_in,
    output D0_out, Valid_out, Ovf_out
  );

endinterface

// File: rtl/fx_mul_round.sv
// Registered signed multiplier; the registered full-width product is rounded
// half-up and shifted down by FRAC_BITS on the way out.
module fx_mul_round
  import alu_pkg::*;
#(
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned FRAC_BITS = 6
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          en_i,
  input  logic signed [WORD_BITS-1:0]   a_i,
  input  logic signed [WORD_BITS-1:0]   b_i,
  output logic signed [2*WORD_BITS-1:0] y_o
);
  localparam int unsigned ProdBits = 2 * WORD_BITS;
  localparam logic signed [ProdBits-1:0] Rnd = ProdBits'(round_shift(FRAC_BITS));

  logic signed [ProdBits-1:0] prod_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prod_q <= '0;
    end else if (en_i) begin
      prod_q <= a_i * b_i;
    end
  end

  assign y_o = (prod_q + Rnd) >>> FRAC_BITS;

endmodule

// File: rtl/alu_stream.sv
// Streaming ALU: window FSM and config capture (S1), accumulate (S2), close
// arithmetic into the output register (S3).
module alu_stream
  import alu_pkg::*;
#(
  parameter int unsigned WORD_BITS = 16,
  parameter int unsigned FRAC_BITS = 6,
  parameter int unsigned MAX_WIN   = 16,
  parameter int unsigned ACC_BITS  = 2 * WORD_BITS + $clog2(MAX_WIN)
) (
  input logic         CLK,
  input logic         RST,
  alu_stream_if.slave bus
);
  localparam int unsigned WinBits = $clog2(MAX_WIN) + 1;
  localparam int unsigned CntBits = $clog2(MAX_WIN) + 2;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  state_e state_q, state_d;

  alu_mode_e          mode_q, cur_mode;
  logic               relu_q, sat_q, cur_relu, cur_sat;
  logic [WinBits-1:0] wlog2_q, cur_wlog2;
  logic [CntBits-1:0] cnt_q, cnt_d;
  logic               first, beat;

  // Window config comes from the inputs on the opening beat, from the latches after.
  always_comb begin
    first     = (state_q == StIdle);
    cur_mode  = first ? decode_mode(bus.CFG_in) : mode_q;
    cur_relu  = first ? bus.ReLU_en_in : relu_q;
    cur_sat   = first ? bus.Sat_en_in : sat_q;
    cur_wlog2 = first ? bus.Win_log2_in : wlog2_q;
    beat      = bus.En_in & bus.S0_valid_in & ((cur_mode != ALU_MAC) | bus.S1_valid_in);
    state_d   = state_q;
    cnt_d     = cnt_q;
    if (beat) begin
      state_d = bus.Last_in ? StIdle : StAccum;
      if (first) begin
        cnt_d = CntBits'(1);
      end else if (cnt_q <= CntBits'(MAX_WIN)) begin
        cnt_d = cnt_q + CntBits'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= ALU_NOP;
      relu_q  <= 1'b0;
      sat_q   <= 1'b0;
      wlog2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (beat && first) begin
        mode_q  <= cur_mode;
        relu_q  <= cur_relu;
        sat_q   <= cur_sat;
        wlog2_q <= cur_wlog2;
      end
    end
  end

  // ---------------- S1: operand register and multiply ----------------
  logic                          p1_valid, p1_first, p1_last, p1_relu, p1_sat, p1_over;
  alu_mode_e                     p1_mode;
  logic [WinBits-1:0]            p1_wlog2;
  logic signed [WORD_BITS-1:0]   p1_bias, p1_s0;
  logic signed [2*WORD_BITS-1:0] mul_y;

  fx_mul_round #(
    .WORD_BITS(WORD_BITS),
    .FRAC_BITS(FRAC_BITS)
  ) u_mul (
    .CLK (CLK),
    .RST (RST),
    .en_i(beat),
    .a_i ($signed(bus.S0_in)),
    .b_i ($signed(bus.S1_in)),
    .y_o (mul_y)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      p1_valid <= 1'b0;
      p1_first <= 1'b0;
      p1_last  <= 1'b0;
      p1_mode  <= ALU_NOP;
      p1_relu  <= 1'b0;
      p1_sat   <= 1'b0;
      p1_wlog2 <= '0;
      p1_bias  <= '0;
      p1_over  <= 1'b0;
      p1_s0    <= '0;
    end else begin
      p1_valid <= beat;
      if (beat) begin
        p1_first <= first;
        p1_last  <= bus.Last_in;
        p1_mode  <= cur_mode;
        p1_relu  <= cur_relu;
        p1_sat   <= cur_sat;
        p1_wlog2 <= cur_wlog2;
        p1_bias  <= $signed(bus.Bias_in);
        p1_over  <= (cnt_d > CntBits'(MAX_WIN));
        p1_s0    <= $signed(bus.S0_in);
      end
    end
  end

  // ---------------- S2: round and accumulate ----------------
  logic signed [ACC_BITS-1:0]  term, acc_d, acc_q;
  logic                        p2_valid, p2_relu, p2_sat, p2_over;
  alu_mode_e                   p2_mode;
  logic [WinBits-1:0]          p2_wlog2;
  logic signed [WORD_BITS-1:0] p2_bias;

  // The first beat of a window loads; MAX's most-negative seed is implied by that.
  always_comb begin
    term  = (p1_mode == ALU_MAC) ? ACC_BITS'(mul_y) : ACC_BITS'(p1_s0);
    acc_d = acc_q;
    if (p1_valid) begin
      if (p1_first) begin
        acc_d = term;
      end else if (p1_mode == ALU_MAX) begin
        acc_d = (term > acc_q) ? term : acc_q;
      end else begin
        acc_d = acc_q + term;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q    <= '0;
      p2_valid <= 1'b0;
      p2_mode  <= ALU_NOP;
      p2_relu  <= 1'b0;
      p2_sat   <= 1'b0;
      p2_wlog2 <= '0;
      p2_bias  <= '0;
      p2_over  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      p2_valid <= p1_valid & p1_last & (p1_mode != ALU_NOP);
      if (p1_valid && p1_last) begin
        p2_mode  <= p1_mode;
        p2_relu  <= p1_relu;
        p2_sat   <= p1_sat;
        p2_wlog2 <= p1_wlog2;
        p2_bias  <= p1_bias;
        p2_over  <= p1_over;
      end
    end
  end

  // ---------------- S3: close arithmetic ----------------
  logic signed [ACC_BITS-1:0] close_v;
  narrow_t                    nar;
  logic [WORD_BITS-1:0]       d0_q;
  logic                       valid_q, ovf_q;

  always_comb begin
    close_v = acc_q;
    if (p2_mode inside {ALU_MAC, ALU_ADD}) begin
      close_v = acc_q + ACC_BITS'(p2_bias);
    end else if (p2_mode == ALU_AVG) begin
      close_v = acc_q >>> p2_wlog2;
    end
    if (p2_relu && close_v[ACC_BITS-1]) begin
      close_v = '0;
    end
    nar = sat_narrow(64'(close_v), WORD_BITS, p2_sat);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      d0_q    <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= p2_valid;
      if (p2_valid) begin
        d0_q  <= nar.value[WORD_BITS-1:0];
        ovf_q <= nar.ovf | p2_over;
      end else begin
        ovf_q <= 1'b0;
      end
    end
  end

  logic unused_nar;
  assign unused_nar = ^nar.value[NarrowBits-1:WORD_BITS];

  assign bus.D0_out    = d0_q;
  assign bus.Valid_out = valid_q;
  assign bus.Ovf_out   = ovf_q;

endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream: spec vectors, multi-cycle corner sequences and random
// traffic, all compared against a window-level arithmetic model.
module tb_alu_stream;
  localparam int unsigned W       = 16;
  localparam int unsigned FRAC    = 6;
  localparam int unsigned MAX_WIN = 16;
  localparam longint      MaxW    = 32767;
  localparam longint      MinW    = -32768;
  localparam longint      Rnd     = 32;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  alu_stream_if #(.WORD_BITS(W), .MAX_WIN(MAX_WIN)) bus ();

  alu_stream #(
    .WORD_BITS(W),
    .FRAC_BITS(FRAC),
    .MAX_WIN  (MAX_WIN)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model (window level) ----------------
  typedef struct {
    int          due;
    logic [15:0] d0;
    logic        ovf;
  } exp_t;

  exp_t        expq[$];
  longint      m_terms[$];
  bit          m_open = 0;
  int          m_mode = 0;
  bit          m_relu = 0;
  bit          m_sat = 0;
  int          m_wl = 0;
  int          m_cnt = 0;
  logic [15:0] m_last_d0 = '0;
  logic [15:0] obs_d0[int];
  logic        obs_ovf[int];

  function automatic int dec(input logic [2:0] c);
    return (c > 3'd4) ? 0 : int'(c);
  endfunction

  function automatic exp_t close_model(input int due, input logic signed [15:0] bias);
    longint v;
    exp_t   e;
    if (m_mode == 3) begin
      v = MinW;
      foreach (m_terms[i]) if (m_terms[i] > v) v = m_terms[i];
    end else begin
      v = 0;
      foreach (m_terms[i]) v += m_terms[i];
    end
    if (m_mode == 1 || m_mode == 2) v += longint'(bias);
    if (m_mode == 4) v = v >>> m_wl;
    if (m_relu && v < 0) v = 0;
    e.due = due;
    e.ovf = (v > MaxW) || (v < MinW) || (m_cnt > int'(MAX_WIN));
    if (m_sat && v > MaxW) e.d0 = 16'(MaxW);
    else if (m_sat && v < MinW) e.d0 = 16'(MinW);
    else e.d0 = v[15:0];
    return e;
  endfunction

  task automatic model_step();
    int     mode;
    bit     beat;
    longint t;
    mode = m_open ? m_mode : dec(bus.CFG_in);
    beat = bus.En_in && bus.S0_valid_in && (mode != 1 || bus.S1_valid_in);
    if (!beat) return;
    if (!m_open) begin
      m_mode = mode;
      m_relu = bus.ReLU_en_in;
      m_sat  = bus.Sat_en_in;
      m_wl   = int'(bus.Win_log2_in);
      m_cnt  = 0;
      m_terms.delete();
    end
    m_cnt++;
    if (mode == 1)
      t = (longint'($signed(bus.S0_in)) * longint'($signed(bus.S1_in)) + Rnd) >>> FRAC;
    else
      t = longint'($signed(bus.S0_in));
    m_terms.push_back(t);
    if (bus.Last_in) begin
      m_open = 0;
      if (mode != 0) expq.push_back(close_model(cyc + 3, $signed(bus.Bias_in)));
    end else begin
      m_open = 1;
    end
  endtask

  task automatic m_reset();
    m_open = 0;
    m_terms.delete();
    expq.delete();
    m_last_d0 = '0;
  endtask

  task automatic check_outputs();
    exp_t e;
    if (bus.Valid_out === 1'b1) begin
      obs_d0[cyc]  = bus.D0_out;
      obs_ovf[cyc] = bus.Ovf_out;
    end
    if (expq.size() != 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      check("valid", bus.Valid_out, 1);
      check("d0", $signed(bus.D0_out), $signed(e.d0));
      check("ovf", bus.Ovf_out, e.ovf);
      m_last_d0 = e.d0;
    end else begin
      check("idle_valid", bus.Valid_out, 0);
      check("idle_ovf", bus.Ovf_out, 0);
      check("hold_d0", $signed(bus.D0_out), $signed(m_last_d0));
    end
  endtask

  task automatic tick();
    if (RST) model_step();
    @(posedge CLK);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic drive(input logic en, input int cfg, input logic relu, input logic sat,
                       input int wl, input logic s0v, input int s0, input logic s1v,
                       input int s1, input logic last, input int bias);
    bus.En_in       = en;
    bus.CFG_in      = 3'(cfg);
    bus.ReLU_en_in  = relu;
    bus.Sat_en_in   = sat;
    bus.Win_log2_in = 5'(wl);
    bus.S0_valid_in = s0v;
    bus.S0_in       = 16'(s0);
    bus.S1_valid_in = s1v;
    bus.S1_in       = 16'(s1);
    bus.Last_in     = last;
    bus.Bias_in     = 16'(bias);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Waits until the cycle a result closed at close_c is due, then checks it.
  task automatic expect_result(input string name, input int close_c,
                               input logic [15:0] d0, input logic ovf);
    int k;
    k = close_c + 3;
    while (cyc < k) tick();
    check({name, "_present"}, obs_d0.exists(k), 1);
    if (obs_d0.exists(k)) begin
      check({name, "_d0"}, $signed(obs_d0[k]), $signed(d0));
      check({name, "_ovf"}, obs_ovf[k], ovf);
    end
  endtask

  // ---------------- spec vectors ----------------
  typedef struct packed {
    logic [2:0]       cfg;
    logic             relu;
    logic             sat;
    logic [4:0]       wl;
    logic [2:0]       n;
    logic [3:0][15:0] s0;
    logic [3:0][15:0] s1;
    logic [15:0]      bias;
    logic [15:0]      d0;
    logic             ovf;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input int cfg, input bit relu, input bit sat, input int wl,
                              input int n, input int a0, input int a1, input int a2,
                              input int a3, input int b0, input int b1, input int bias,
                              input int d0, input bit ovf);
    vec_t v;
    v.cfg = 3'(cfg); v.relu = relu; v.sat = sat; v.wl = 5'(wl); v.n = 3'(n);
    v.s0[0] = 16'(a0); v.s0[1] = 16'(a1); v.s0[2] = 16'(a2); v.s0[3] = 16'(a3);
    v.s1[0] = 16'(b0); v.s1[1] = 16'(b1); v.s1[2] = '0; v.s1[3] = '0;
    v.bias = 16'(bias); v.d0 = 16'(d0); v.ovf = ovf;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, output int close_c);
    close_c = cyc;
    for (int b = 0; b < int'(v.n); b++) begin
      drive(1, int'(v.cfg), v.relu, v.sat, int'(v.wl), 1, int'(v.s0[b]), 1, int'(v.s1[b]),
            b == int'(v.n) - 1, int'(v.bias));
      close_c = cyc;
      tick();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c1, c2, c3, c4;
    vecs[0]  = mk(1, 0, 0, 0, 2, 96, 64, 0, 0, 128, 64, 64, 320, 0);
    vecs[1]  = mk(2, 0, 1, 0, 2, 32767, 32767, 0, 0, 0, 0, 0, 32767, 1);
    vecs[2]  = mk(2, 0, 0, 0, 2, 32767, 32767, 0, 0, 0, 0, 0, -2, 1);
    vecs[3]  = mk(3, 0, 0, 0, 3, -5, 7, 3, 0, 0, 0, 0, 7, 0);
    vecs[4]  = mk(4, 0, 0, 2, 4, 64, 128, 192, 256, 0, 0, 0, 160, 0);
    vecs[5]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 32, 0, 0, 1, 0);
    vecs[6]  = mk(1, 0, 0, 0, 1, -1, 0, 0, 0, 32, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0, 1, -128, 0, 0, 0, 64, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 1, -128, 0, 0, 0, 64, 0, 0, -128, 0);
    vecs[9]  = mk(2, 1, 0, 0, 2, 10, 20, 0, 0, 0, 0, -100, 0, 0);
    vecs[10] = mk(2, 0, 0, 0, 2, 10, 20, 0, 0, 0, 0, -100, -70, 0);

    RST = 1'b0;
    idle();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid", bus.Valid_out, 0);
    check("rst_ovf", bus.Ovf_out, 0);
    check("rst_d0", $signed(bus.D0_out), 0);
    RST = 1'b1;
    repeat (2) tick();

    foreach (vecs[i]) begin
      run_vec(vecs[i], c);
      expect_result($sformatf("vec%0d", i), c, vecs[i].d0, vecs[i].ovf);
    end

    // MAX window then AVG window starting the very next cycle
    run_vec(vecs[3], c1);
    run_vec(vecs[4], c2);
    expect_result("b2b_max", c1, 16'd7, 1'b0);
    expect_result("b2b_avg", c2, 16'd160, 1'b0);

    // single-beat windows every cycle
    run_vec(vecs[5], c1);
    run_vec(vecs[8], c2);
    run_vec(vecs[6], c3);
    run_vec(vecs[7], c4);
    expect_result("burst0", c1, 16'd1, 1'b0);
    expect_result("burst1", c2, 16'hFF80, 1'b0);
    expect_result("burst2", c3, 16'd0, 1'b0);
    expect_result("burst3", c4, 16'd0, 1'b0);

    // bubbles, En low, missing S1 and a mid-window config change
    drive(1, 1, 0, 0, 0, 1, 96, 1, 128, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 500, 1, 7, 1, 0); tick();
    drive(0, 1, 0, 0, 0, 1, 500, 1, 7, 1, 0); tick();
    drive(1, 1, 0, 0, 0, 1, 500, 0, 7, 1, 0); tick();
    drive(1, 2, 1, 1, 3, 1, 64, 1, 64, 1, 64); c = cyc; tick();
    idle();
    expect_result("gaps", c, 16'd320, 1'b0);

    // window length at and beyond MAX_WIN
    for (int b = 0; b < 16; b++) begin
      drive(1, 2, 0, 1, 0, 1, 1, 0, 0, b == 15, 0); c = cyc; tick();
    end
    idle();
    expect_result("win16", c, 16'd16, 1'b0);
    for (int b = 0; b < 17; b++) begin
      drive(1, 2, 0, 1, 0, 1, 1, 0, 0, b == 16, 0); c = cyc; tick();
    end
    idle();
    expect_result("win17", c, 16'd17, 1'b1);

    // NOP and undefined-mode windows produce nothing
    drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 1, 5, 1, 5, 1, 0); tick();
    drive(1, 6, 0, 0, 0, 1, 5, 1, 5, 1, 0); tick();
    idle();
    repeat (5) tick();

    // reset in the middle of an open window
    drive(1, 1, 0, 0, 0, 1, 96, 1, 128, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 1, 96, 1, 128, 0, 0); tick();
    RST = 1'b0;
    #1;
    check("rstmid_valid", bus.Valid_out, 0);
    check("rstmid_d0", $signed(bus.D0_out), 0);
    m_reset();
    idle();
    repeat (2) tick();
    RST = 1'b1;
    run_vec(vecs[0], c);
    expect_result("post_rstmid", c, 16'd320, 1'b0);

    // reset one cycle after a closing beat discards the in-flight result
    run_vec(vecs[3], c);
    RST = 1'b0;
    #1;
    check("rstflight_valid", bus.Valid_out, 0);
    check("rstflight_ovf", bus.Ovf_out, 0);
    check("rstflight_d0", $signed(bus.D0_out), 0);
    m_reset();
    repeat (4) tick();
    RST = 1'b1;
    run_vec(vecs[0], c);
    expect_result("post_rstflight", c, 16'd320, 1'b0);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0,
            int'($urandom), $urandom_range(0, 3) != 0, int'($urandom),
            $urandom_range(0, 3) == 0, int'($urandom));
      tick();
    end
    idle();
    drive(1, 2, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    tick();
    idle();
    repeat (6) tick();
    check("drain_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
